// File: rtl/wb_port_arbiter.sv
// Writeback write-port arbiter: loads win, ALU results wait in an in-order FIFO.
// Optional WB_ALU_BYPASS_EN lets an ALU result skip an empty, idle FIFO.
module wb_port_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               alu_valid,
  output logic                               alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]          alu_rd,
  input  logic [BUS_DATA_WIDTH-1:0]          alu_data,
  input  logic                               ld_valid,
  input  logic [REG_ADDR_WIDTH-1:0]          ld_rd,
  input  logic [BUS_DATA_WIDTH-1:0]          ld_data,
  input  logic                               flush,
  output logic                               rf_wr_en,
  output logic [REG_ADDR_WIDTH-1:0]          rf_wr_addr,
  output logic [BUS_DATA_WIDTH-1:0]          rf_wr_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [REG_ADDR_WIDTH-1:0] rdMem   [FIFO_DEPTH];
  logic [BUS_DATA_WIDTH-1:0] dataMem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wrPtr, rdPtr;
  logic [CNT_W-1:0]          count;

  logic                      ldGrant, aluTake, headGrant, bypassGrant, push, grant;
  logic [REG_ADDR_WIDTH-1:0] selAddr;
  logic [BUS_DATA_WIDTH-1:0] selData;

  assign alu_ready  = (count < CNT_W'(FIFO_DEPTH));
  assign fifo_count = count;
  assign busy       = (count != '0);

  // rd==0 results are accepted (handshake completes) but never reach the port
  always_comb begin
    ldGrant   = ld_valid && (ld_rd != '0);
    aluTake   = alu_valid && alu_ready && !flush && (alu_rd != '0);
    headGrant = !ldGrant && !flush && (count != '0);
`ifdef WB_ALU_BYPASS_EN
    bypassGrant = !ldGrant && (count == '0) && aluTake;
`else
    bypassGrant = 1'b0;
`endif
    push  = aluTake && !bypassGrant;
    grant = ldGrant || headGrant || bypassGrant;

    selAddr = ld_rd;
    selData = ld_data;
    if (!ldGrant && headGrant) begin
      selAddr = rdMem[rdPtr];
      selData = dataMem[rdPtr];
    end else if (!ldGrant) begin
      selAddr = alu_rd;
      selData = alu_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      count      <= '0;
      wrPtr      <= '0;
      rdPtr      <= '0;
    end else begin
      rf_wr_en <= grant;
      if (grant) begin
        rf_wr_addr <= selAddr;
        rf_wr_data <= selData;
      end
      if (flush) begin
        count <= '0;
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push)      wrPtr <= wrPtr + PTR_W'(1);
        if (headGrant) rdPtr <= rdPtr + PTR_W'(1);
        case ({push, headGrant})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // storage needs no reset: the count alone defines which entries are live
  always_ff @(posedge clk) begin
    if (push) begin
      rdMem[wrPtr]   <= alu_rd;
      dataMem[wrPtr] <= alu_data;
    end
  end

endmodule
